// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_pkg
//  Description : Shared constants for the seven-segment scan controller.
//                Segment bytes are active-low, bit order {a,b,c,d,e,f,g,dp},
//                so bit 7 is segment a and bit 0 is the decimal point.
//  Revision    : 1.0  initial release
// ============================================================================
package ssd_pkg;

    localparam logic [7:0] SS_0     = 8'h03;
    localparam logic [7:0] SS_1     = 8'h9F;
    localparam logic [7:0] SS_2     = 8'h25;
    localparam logic [7:0] SS_3     = 8'h0D;
    localparam logic [7:0] SS_4     = 8'h99;
    localparam logic [7:0] SS_5     = 8'h49;
    localparam logic [7:0] SS_6     = 8'h41;
    localparam logic [7:0] SS_7     = 8'h1F;
    localparam logic [7:0] SS_8     = 8'h01;
    localparam logic [7:0] SS_9     = 8'h09;
    localparam logic [7:0] SS_P     = 8'h31;
    localparam logic [7:0] SS_A     = 8'h11;
    localparam logic [7:0] SS_F     = 8'h71;
    localparam logic [7:0] SS_BLANK = 8'hFF;

    localparam logic [3:0] CODE_P   = 4'd10;
    localparam logic [3:0] CODE_A   = 4'd11;

endpackage : ssd_pkg
`default_nettype wire

// File: rtl/ssd_glyph_dec.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_glyph_dec
//  Description : Combinational glyph decoder. Maps a 4-bit digit code to an
//                active-low segment byte {a..g,dp}. Codes 12-15 all show F.
//                A suppressed digit has segments a-g off but keeps its dp.
//  Ports       : i_code     digit code
//                i_dp       decimal point request (clears bit 0)
//                i_suppress leading-zero suppression for this digit
//                o_seg      active-low segments
//  Revision    : 1.0  initial release
// ============================================================================
module ssd_glyph_dec
    import ssd_pkg::*;
(
    input  logic [3:0] i_code,
    input  logic       i_dp,
    input  logic       i_suppress,
    output logic [7:0] o_seg
);

    logic [7:0] w_base;

    always_comb begin
        w_base = SS_F;
        case (i_code)
            4'd0:   w_base = SS_0;
            4'd1:   w_base = SS_1;
            4'd2:   w_base = SS_2;
            4'd3:   w_base = SS_3;
            4'd4:   w_base = SS_4;
            4'd5:   w_base = SS_5;
            4'd6:   w_base = SS_6;
            4'd7:   w_base = SS_7;
            4'd8:   w_base = SS_8;
            4'd9:   w_base = SS_9;
            CODE_P: w_base = SS_P;
            CODE_A: w_base = SS_A;
            default: w_base = SS_F;
        endcase
        if (i_suppress) begin
            w_base = SS_BLANK;
        end
        o_seg = {w_base[7:1], w_base[0] & ~i_dp};
    end

endmodule : ssd_glyph_dec
`default_nettype wire

// File: rtl/ssd_scan_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_scan_ctl
//  Description : N-digit multiplexed seven-segment scan controller with
//                frame-synchronous double buffering, per-digit dp/blank/blink,
//                leading-zero suppression, PWM brightness and a dark dead
//                cycle at the start of every digit slot.
//  Ports       : f_cst      clock
//                rst        synchronous active-high reset
//                dsp        digit codes, digit i = dsp[4i+3:4i], digit 0 right
//                dp/blank/blink  per-digit attributes (buffered)
//                lz_en      leading-zero suppression (live)
//                bright     PWM duty, 0 dark, all-ones full on (live)
//                load       capture digit data into the pending buffer
//                upd_pend   pending buffer waiting for frame boundary
//                BCD        active-low segments {a..g,dp}
//                BCD_c      active-low one-hot digit enables
//                frame_tick one-cycle pulse after each completed frame
//  Revision    : 1.0  initial release
// ============================================================================
module ssd_scan_ctl
    import ssd_pkg::*;
#(
    parameter int N_DIG     = 4,
    parameter int SCAN_DIV  = 18,
    parameter int BLINK_DIV = 7,
    parameter int PWM_BITS  = 4
) (
    input  logic                  f_cst,
    input  logic                  rst,
    input  logic [4*N_DIG-1:0]    dsp,
    input  logic [N_DIG-1:0]      dp,
    input  logic [N_DIG-1:0]      blank,
    input  logic [N_DIG-1:0]      blink,
    input  logic                  lz_en,
    input  logic [PWM_BITS-1:0]   bright,
    input  logic                  load,
    output logic                  upd_pend,
    output logic [7:0]            BCD,
    output logic [N_DIG-1:0]      BCD_c,
    output logic                  frame_tick
);

    localparam int                 c_IDX_W    = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_DIG - 1);

    // scan counters
    logic [SCAN_DIV-1:0]  r_cnt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [BLINK_DIV-1:0] r_blink_ctr;

    // active (displayed) and pending buffers
    logic [4*N_DIG-1:0]   r_act_dsp,   r_pnd_dsp;
    logic [N_DIG-1:0]     r_act_dp,    r_pnd_dp;
    logic [N_DIG-1:0]     r_act_blank, r_pnd_blank;
    logic [N_DIG-1:0]     r_act_blink, r_pnd_blink;
    logic                 r_upd_pend;

    // output registers
    logic [7:0]           r_bcd;
    logic [N_DIG-1:0]     r_bcd_c;
    logic                 r_frame_tick;

    logic                 w_slot_end;
    logic                 w_frame_end;
    logic [3:0]           w_code;
    logic [N_DIG-1:0]     w_zero_run;
    logic                 w_run;
    logic                 w_supp;
    logic                 w_pwm_on;
    logic                 w_lit;
    logic [7:0]           w_seg;
    logic [N_DIG-1:0]     w_an;

    assign w_slot_end  = &r_cnt;
    assign w_frame_end = w_slot_end && (r_idx == c_IDX_LAST);

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    always_ff @(posedge f_cst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_blink_ctr <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_slot_end) begin
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end
            if (w_frame_end) begin
                r_blink_ctr <= r_blink_ctr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Double buffer. A load coinciding with frame_end bypasses the
    // pending stage so the new data is visible in the very next frame.
    // ------------------------------------------------------------------
    always_ff @(posedge f_cst) begin
        if (rst) begin
            r_act_dsp   <= '0;
            r_act_dp    <= '0;
            r_act_blank <= '0;
            r_act_blink <= '0;
            r_pnd_dsp   <= '0;
            r_pnd_dp    <= '0;
            r_pnd_blank <= '0;
            r_pnd_blink <= '0;
            r_upd_pend  <= 1'b0;
        end else begin
            if (load) begin
                r_pnd_dsp   <= dsp;
                r_pnd_dp    <= dp;
                r_pnd_blank <= blank;
                r_pnd_blink <= blink;
            end
            if (w_frame_end && load) begin
                r_act_dsp   <= dsp;
                r_act_dp    <= dp;
                r_act_blank <= blank;
                r_act_blink <= blink;
                r_upd_pend  <= 1'b0;
            end else if (w_frame_end && r_upd_pend) begin
                r_act_dsp   <= r_pnd_dsp;
                r_act_dp    <= r_pnd_dp;
                r_act_blank <= r_pnd_blank;
                r_act_blink <= r_pnd_blink;
                r_upd_pend  <= 1'b0;
            end else if (load) begin
                r_upd_pend  <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero chain: w_zero_run[i] is set when digit i and every
    // digit above it hold code 0.
    // ------------------------------------------------------------------
    always_comb begin
        w_run      = 1'b1;
        w_zero_run = '0;
        for (int i = N_DIG - 1; i >= 0; i--) begin
            w_run         = w_run && (r_act_dsp[4*i +: 4] == 4'd0);
            w_zero_run[i] = w_run;
        end
    end

    assign w_code   = r_act_dsp[{r_idx, 2'b00} +: 4];
    assign w_supp   = lz_en && (r_idx != '0) && w_zero_run[r_idx];
    assign w_pwm_on = (r_cnt[PWM_BITS-1:0] < bright) || (&bright);

    // A suppressed digit with no dp has nothing to show, so it is kept dark.
    assign w_lit = !r_act_blank[r_idx]
                && !(r_act_blink[r_idx] && r_blink_ctr[BLINK_DIV-1])
                && (r_cnt != '0)
                && w_pwm_on
                && !(w_supp && !r_act_dp[r_idx]);

    ssd_glyph_dec u_glyph (
        .i_code     (w_code),
        .i_dp       (r_act_dp[r_idx]),
        .i_suppress (w_supp),
        .o_seg      (w_seg)
    );

    always_comb begin
        w_an = '1;
        for (int i = 0; i < N_DIG; i++) begin
            if (w_lit && (r_idx == c_IDX_W'(i))) begin
                w_an[i] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge f_cst) begin
        if (rst) begin
            r_bcd        <= SS_BLANK;
            r_bcd_c      <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_bcd        <= w_lit ? w_seg : SS_BLANK;
            r_bcd_c      <= w_an;
            r_frame_tick <= w_frame_end;
        end
    end

    assign BCD        = r_bcd;
    assign BCD_c      = r_bcd_c;
    assign frame_tick = r_frame_tick;
    assign upd_pend   = r_upd_pend;

endmodule : ssd_scan_ctl
`default_nettype wire

// File: tb/tb_ssd_scan_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ssd_scan_ctl
//  Description : Randomized self-checking bench for ssd_scan_ctl with a
//                cycle-indexed reference model (N_DIG=4, SCAN_DIV=4,
//                PWM_BITS=2, BLINK_DIV=1).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ssd_scan_ctl;

    localparam int N_DIG     = 4;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 1;
    localparam int PWM_BITS  = 2;
    localparam int SLOT      = 1 << SCAN_DIV;
    localparam int FRAME     = SLOT * N_DIG;

    logic        f_cst  = 1'b0;
    logic        rst    = 1'b1;
    logic [15:0] dsp    = '0;
    logic [3:0]  dp     = '0;
    logic [3:0]  blank  = '0;
    logic [3:0]  blink  = '0;
    logic        lz_en  = 1'b0;
    logic [1:0]  bright = 2'd3;
    logic        load   = 1'b0;
    logic        upd_pend;
    logic [7:0]  BCD;
    logic [3:0]  BCD_c;
    logic        frame_tick;

    always #5 f_cst = ~f_cst;

    ssd_scan_ctl #(
        .N_DIG     (N_DIG),
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV),
        .PWM_BITS  (PWM_BITS)
    ) dut (
        .f_cst      (f_cst),
        .rst        (rst),
        .dsp        (dsp),
        .dp         (dp),
        .blank      (blank),
        .blink      (blink),
        .lz_en      (lz_en),
        .bright     (bright),
        .load       (load),
        .upd_pend   (upd_pend),
        .BCD        (BCD),
        .BCD_c      (BCD_c),
        .frame_tick (frame_tick)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] glyph_of(input logic [3:0] code);
        case (code)
            4'd0:  return 8'h03;
            4'd1:  return 8'h9F;
            4'd2:  return 8'h25;
            4'd3:  return 8'h0D;
            4'd4:  return 8'h99;
            4'd5:  return 8'h49;
            4'd6:  return 8'h41;
            4'd7:  return 8'h1F;
            4'd8:  return 8'h01;
            4'd9:  return 8'h09;
            4'd10: return 8'h31;
            4'd11: return 8'h11;
            default: return 8'h71;
        endcase
    endfunction

    // reference model state: t = clocks since reset release
    int          t = 0;
    logic [15:0] a_dsp = '0, p_dsp = '0;
    logic [3:0]  a_dp = '0, a_bl = '0, a_bk = '0;
    logic [3:0]  p_dp = '0, p_bl = '0, p_bk = '0;
    bit          m_pend = 1'b0;

    function automatic bit at_frame_end();
        return !rst && ((t % FRAME) == FRAME - 1);
    endfunction

    // one clock: predict, advance, compare, update model
    task automatic cycle();
        logic [7:0] e_bcd;
        logic [3:0] e_an;
        logic [3:0] code;
        bit         e_tick, e_pend, fe, phase, supp, lit;
        int         cnt, idx, fc;
        e_bcd = 8'hFF; e_an = 4'hF; e_tick = 1'b0; e_pend = 1'b0; fe = 1'b0;
        if (!rst) begin
            cnt   = t % SLOT;
            idx   = (t / SLOT) % N_DIG;
            fc    = t / FRAME;
            phase = ((fc >> (BLINK_DIV - 1)) & 1) != 0;
            fe    = (t % FRAME) == FRAME - 1;
            code  = a_dsp[4*idx +: 4];
            supp  = lz_en && (idx != 0) && ((a_dsp >> (4*idx)) == 16'd0);
            lit   = !a_bl[idx] && !(a_bk[idx] && phase) && (cnt != 0)
                 && (((cnt % (1 << PWM_BITS)) < int'(bright)) || (bright == 2'd3))
                 && !(supp && !a_dp[idx]);
            if (lit) begin
                e_an  = ~(4'b0001 << idx);
                e_bcd = supp ? 8'hFE : (glyph_of(code) & (a_dp[idx] ? 8'hFE : 8'hFF));
            end
            e_tick = fe;
            e_pend = load ? !fe : (fe ? 1'b0 : m_pend);
        end
        @(posedge f_cst);
        #1;
        check_val("BCD",        32'(BCD),        32'(e_bcd));
        check_val("BCD_c",      32'(BCD_c),      32'(e_an));
        check_val("upd_pend",   32'(upd_pend),   32'(e_pend));
        check_val("frame_tick", 32'(frame_tick), 32'(e_tick));
        if (rst) begin
            t = 0; m_pend = 1'b0;
            a_dsp = '0; a_dp = '0; a_bl = '0; a_bk = '0;
            p_dsp = '0; p_dp = '0; p_bl = '0; p_bk = '0;
        end else begin
            if (fe && load) begin
                a_dsp = dsp; a_dp = dp; a_bl = blank; a_bk = blink;
            end else if (fe && m_pend) begin
                a_dsp = p_dsp; a_dp = p_dp; a_bl = p_bl; a_bk = p_bk;
            end
            if (load) begin
                p_dsp = dsp; p_dp = dp; p_bl = blank; p_bk = blink;
            end
            m_pend = e_pend;
            t++;
        end
    endtask

    task automatic rand_data();
        for (int k = 0; k < 4; k++) begin
            dsp[4*k +: 4] = ($urandom % 2 == 0) ? 4'd0 : 4'($urandom % 16);
            blank[k]      = ($urandom % 8 == 0);
        end
        dp    = 4'($urandom % 16);
        blink = 4'($urandom % 16);
    endtask

    logic [1:0] bright_seq [4];

    initial begin
        bright_seq[0] = 2'd3; bright_seq[1] = 2'd1;
        bright_seq[2] = 2'd0; bright_seq[3] = 2'd2;

        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;

        for (int ph = 0; ph < 8; ph++) begin
            bright = bright_seq[ph % 4];
            lz_en  = (ph >= 4);
            for (int c = 0; c < 600; c++) begin
                load = 1'b0;
                if ((at_frame_end() && ($urandom % 3 == 0)) || ($urandom % 30 == 0)) begin
                    load = 1'b1;
                    rand_data();
                end
                if (ph == 5 && c == 300) begin
                    rst = 1'b1;
                end else if (ph == 5 && c == 302) begin
                    rst = 1'b0;
                end
                cycle();
            end
        end
        load = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ssd_scan_ctl
`default_nettype wire
